// File: rtl/conv_stride_stream.sv
// Streaming strided convolution: K-row line buffer, sequential K*K*C signed MAC per window,
// valid/ready result with end-of-frame flag. Optional macro CONV_RELU_EN clamps negative results to 0.
module conv_stride_stream #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int K      = 2,
    parameter int C      = 3,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int STRIDE = 1,
    localparam int ACC_W = DATA_W + WGT_W + $clog2(K * K * C)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WGT_W-1:0]  kernal_weights [0:K-1][0:K-1][0:C-1],
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int N      = K * K * C;
    localparam int PW     = DATA_W + WGT_W;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CHW    = (C > 1) ? $clog2(C) : 1;
    localparam int KB     = (K > 1) ? $clog2(K) : 1;
    localparam int NW     = $clog2(N + 1);
    localparam int LAST_R = (STRIDE > 0) ? IMG_H - 1 - ((IMG_H - K) % STRIDE) : 0;
    localparam int LAST_C = (STRIDE > 0) ? IMG_W - 1 - ((IMG_W - K) % STRIDE) : 0;

    localparam logic [1:0] S_ACCEPT  = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    if (IMG_W < K) begin : g_err_img_w
        $error("conv_stride_stream: IMG_W must be >= K");
    end
    if (IMG_H < K) begin : g_err_img_h
        $error("conv_stride_stream: IMG_H must be >= K");
    end
    if (STRIDE < 1) begin : g_err_stride
        $error("conv_stride_stream: STRIDE must be >= 1");
    end

    logic [1:0]               state;
    logic [RW-1:0]            r;
    logic [CW-1:0]            c;
    logic [CHW-1:0]           ch;
    logic [KB-1:0]            wr_row;
    logic [KB-1:0]            rsel;
    logic [KB-1:0]            kh;
    logic [KB-1:0]            kw;
    logic [CHW-1:0]           kch;
    logic [CW-1:0]            c0;
    logic [NW-1:0]            cnt;
    logic                     win_last;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  result;
    logic signed [DATA_W-1:0] pix;
    logic signed [WGT_W-1:0]  wgt;
    logic                     xfer;
    logic                     trigger;

    logic signed [DATA_W-1:0] lbuf [0:K-1][0:IMG_W-1][0:C-1];

    assign in_ready = (state == S_ACCEPT) && !rst;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        trigger = (ch == CHW'(C - 1)) && (r >= RW'(K - 1)) && (c >= CW'(K - 1)) &&
                  ((int'(r) - (K - 1)) % STRIDE == 0) &&
                  ((int'(c) - (K - 1)) % STRIDE == 0);
    end

    // rsel walks the physical line-buffer rows starting at the window's top row.
    assign pix = lbuf[rsel][c0 + CW'(kw)][kch];
    assign wgt = kernal_weights[kh][kw][kch];
    assign sum = acc + ACC_W'(prod);

`ifdef CONV_RELU_EN
    assign result = sum[ACC_W-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    always_ff @(posedge clk) begin
        if (xfer) begin
            lbuf[wr_row][c][ch] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ACCEPT;
            r         <= '0;
            c         <= '0;
            ch        <= '0;
            wr_row    <= '0;
            rsel      <= '0;
            kh        <= '0;
            kw        <= '0;
            kch       <= '0;
            c0        <= '0;
            cnt       <= '0;
            win_last  <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_ACCEPT: begin
                    if (xfer) begin
                        if (ch == CHW'(C - 1)) begin
                            ch <= '0;
                            if (c == CW'(IMG_W - 1)) begin
                                c <= '0;
                                if (r == RW'(IMG_H - 1)) begin
                                    r      <= '0;
                                    wr_row <= '0;
                                end else begin
                                    r      <= r + RW'(1);
                                    wr_row <= (wr_row == KB'(K - 1)) ? '0 : wr_row + KB'(1);
                                end
                            end else begin
                                c <= c + CW'(1);
                            end
                        end else begin
                            ch <= ch + CHW'(1);
                        end
                        if (trigger) begin
                            c0       <= c - CW'(K - 1);
                            rsel     <= (wr_row == KB'(K - 1)) ? '0 : wr_row + KB'(1);
                            win_last <= (r == RW'(LAST_R)) && (c == CW'(LAST_C));
                            kh       <= '0;
                            kw       <= '0;
                            kch      <= '0;
                            cnt      <= '0;
                            acc      <= '0;
                            state    <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    // Product stage runs one cycle ahead of the accumulate stage.
                    if (cnt == NW'(N)) begin
                        out_data  <= result;
                        out_last  <= win_last;
                        out_valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        prod <= PW'(pix) * PW'(wgt);
                        if (cnt != '0) begin
                            acc <= sum;
                        end
                        cnt <= cnt + NW'(1);
                        if (kch == CHW'(C - 1)) begin
                            kch <= '0;
                            if (kw == KB'(K - 1)) begin
                                kw   <= '0;
                                kh   <= kh + KB'(1);
                                rsel <= (rsel == KB'(K - 1)) ? '0 : rsel + KB'(1);
                            end else begin
                                kw <= kw + KB'(1);
                            end
                        end else begin
                            kch <= kch + CHW'(1);
                        end
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= S_ACCEPT;
                    end
                end
                default: state <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stride_stream.sv
// Directed bench for conv_stride_stream: table of full-frame scenarios plus hand-written
// backpressure and mid-compute reset sequences. Expected values are hand computed.
module tb_conv_stride_stream;

    localparam int AW = 20;

    typedef struct packed {
        int                   dut;
        int                   mode;
        int                   gap_at;
        int                   gap_len;
        int                   n_out;
        logic [8:0][AW-1:0]   exp;
        logic [8:0]           last;
    } scen_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [7:0]    in_data;
    logic                 in_valid;
    int                   sel;
    logic signed [7:0]    wgt [0:1][0:1][0:2];
    logic                 in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic                 out_valid_a, out_valid_b, out_last_a, out_last_b, ready_a;
    logic signed [AW-1:0] out_data_a, out_data_b;

    assign in_valid_a = in_valid && (sel == 0);
    assign in_valid_b = in_valid && (sel == 1);

    conv_stride_stream #(.DATA_W(8), .WGT_W(8), .K(2), .C(3), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .kernal_weights(wgt), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(ready_a), .out_last(out_last_a)
    );

    conv_stride_stream #(.DATA_W(8), .WGT_W(8), .K(2), .C(3), .IMG_W(4), .IMG_H(4), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .kernal_weights(wgt), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(1'b1), .out_last(out_last_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [AW-1:0] q_data_a[$], q_data_b[$];
    logic                 q_last_a[$], q_last_b[$];
    int                   last_acc_a = 0, last_acc_b = 0;
    logic                 prev_a = 1'b0, prev_b = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Collect transfers and check trigger-to-valid latency (13 edges for K=2, C=3).
    always @(negedge clk) begin
        if (rst) begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end else begin
            if (in_valid_a && in_ready_a) last_acc_a = cyc + 1;
            if (in_valid_b && in_ready_b) last_acc_b = cyc + 1;
            if (out_valid_a && !prev_a) chk("latency_a", cyc - last_acc_a, 13);
            if (out_valid_b && !prev_b) chk("latency_b", cyc - last_acc_b, 13);
            if (out_valid_a && ready_a) begin
                q_data_a.push_back(out_data_a);
                q_last_a.push_back(out_last_a);
            end
            if (out_valid_b) begin
                q_data_b.push_back(out_data_b);
                q_last_b.push_back(out_last_b);
            end
            prev_a = out_valid_a;
            prev_b = out_valid_b;
        end
    end

    task automatic set_weights(input int mode);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 3; k++)
                    wgt[i][j][k] = (mode == 0) ? 8'(i + j + k) : 8'sd1;
    endtask

    task automatic clear_queues();
        q_data_a.delete(); q_last_a.delete();
        q_data_b.delete(); q_last_b.delete();
    endtask

    // Called and returns at posedge+1.
    task automatic drive_frame(input int mode, input int n_elem, input int gap_at, input int gap_len);
        for (int i = 0; i < n_elem; i++) begin
            bit accepted;
            int waitc;
            in_valid = 1'b1;
            if (mode == 0) in_data = 8'(i);
            else in_data = 8'hFF;
            accepted = 1'b0;
            waitc = 0;
            while (!accepted) begin
                @(negedge clk);
                accepted = (sel == 0) ? in_ready_a : in_ready_b;
                @(posedge clk); #1;
                waitc++;
                if (!accepted && waitc > 300) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout: element %0d not accepted after %0d cycles, required within 300", i, waitc);
                    in_valid = 1'b0;
                    return;
                end
            end
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int dut, input int n);
        int w;
        w = 0;
        while (((dut == 0) ? q_data_a.size() : q_data_b.size()) < n && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        chk("out_count", (dut == 0) ? q_data_a.size() : q_data_b.size(), n);
    endtask

    task automatic compare(input scen_t sc, input string tag);
        logic signed [AW-1:0] d[$];
        logic                 l[$];
        if (sc.dut == 0) begin d = q_data_a; l = q_last_a; end
        else begin d = q_data_b; l = q_last_b; end
        for (int k = 0; k < sc.n_out && k < d.size(); k++) begin
            chk({tag, "_data"}, int'(d[k]), int'(signed'(sc.exp[k])));
            chk({tag, "_last"}, int'(l[k]), int'(sc.last[k]));
        end
    endtask

    scen_t tbl[4];
    string names[4] = '{"ramp_s1", "ramp_s2", "ramp_gap", "neg_ones"};

    initial begin
        int ramp9[9];
        int ramp4[4];
        int neg;
        ramp9 = '{257, 329, 401, 545, 617, 689, 833, 905, 977};
        ramp4 = '{257, 401, 833, 977};
`ifdef CONV_RELU_EN
        neg = 0;
`else
        neg = -12;
`endif
        for (int s = 0; s < 4; s++) tbl[s] = '0;
        tbl[0].dut = 0; tbl[0].mode = 0; tbl[0].gap_at = -1; tbl[0].n_out = 9;
        tbl[1].dut = 1; tbl[1].mode = 0; tbl[1].gap_at = -1; tbl[1].n_out = 4;
        tbl[2].dut = 0; tbl[2].mode = 0; tbl[2].gap_at = 22; tbl[2].gap_len = 5; tbl[2].n_out = 9;
        tbl[3].dut = 0; tbl[3].mode = 1; tbl[3].gap_at = -1; tbl[3].n_out = 9;
        for (int k = 0; k < 9; k++) begin
            tbl[0].exp[k] = AW'(ramp9[k]);
            tbl[2].exp[k] = AW'(ramp9[k]);
            tbl[3].exp[k] = AW'(neg);
        end
        for (int k = 0; k < 4; k++) tbl[1].exp[k] = AW'(ramp4[k]);
        tbl[0].last[8] = 1'b1;
        tbl[1].last[3] = 1'b1;
        tbl[2].last[8] = 1'b1;
        tbl[3].last[8] = 1'b1;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 0; ready_a = 1'b1;
        set_weights(0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_last", out_last_a, 0);
        chk("rst_out_data", out_data_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready_a, 1);
        @(posedge clk); #1;

        for (int s = 0; s < 4; s++) begin
            sel = tbl[s].dut;
            set_weights(tbl[s].mode);
            clear_queues();
            drive_frame(tbl[s].mode, 48, tbl[s].gap_at, tbl[s].gap_len);
            wait_outputs(tbl[s].dut, tbl[s].n_out);
            compare(tbl[s], names[s]);
        end

        // Backpressure on the first result of a frame.
        sel = 0;
        set_weights(0);
        clear_queues();
        ready_a = 1'b0;
        fork
            drive_frame(0, 48, -1, 0);
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid_a && w < 300) begin @(negedge clk); w++; end
                chk("bp_valid_seen", out_valid_a, 1);
                for (int t = 0; t < 20; t++) begin
                    chk("bp_valid", out_valid_a, 1);
                    chk("bp_data", out_data_a, 257);
                    chk("bp_in_ready", in_ready_a, 0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                ready_a = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("bp_valid_after", out_valid_a, 0);
                chk("bp_in_ready_after", in_ready_a, 1);
            end
        join
        @(posedge clk); #1;
        wait_outputs(0, 9);
        compare(tbl[0], "bp");

        // Reset during the second window's compute.
        clear_queues();
        drive_frame(0, 21, -1, 0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("pre_abort_count", q_data_a.size(), 1);
        if (q_data_a.size() > 0) chk("pre_abort_data", int'(q_data_a[0]), 257);
        clear_queues();
        repeat (30) begin @(posedge clk); #1; end
        chk("abort_no_output", q_data_a.size(), 0);
        chk("abort_out_valid", out_valid_a, 0);
        drive_frame(0, 48, -1, 0);
        wait_outputs(0, 9);
        compare(tbl[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
